mem_line_arbiter: RTL and testbench

- Shares the single line-wide memory port between the instruction cache (line fills only) and the data cache (line fills and dirty-line write-backs).
- Sequences each transfer over a fixed memory latency, latches the returned line, and pulses a per-requester ready.
- Sits between both caches and the 64-bit-line memory model.
- Arbitration: D-cache priority with anti-starvation alternation.

---
 rtl/mem_line_arbiter.sv | 71 +++++++
 tb/tb_mem_line_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: shares one line-wide memory port between I-cache fills and D-cache fills/write-backs
module mem_line_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int LINE_SIZE   = 64,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_readM,
  input  logic [WORD_SIZE-1:0] i_address,
  output logic [LINE_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [LINE_SIZE-1:0] d_wdata,
  output logic [LINE_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 mem_readM,
  output logic                 mem_writeM,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [LINE_SIZE-1:0] mem_wdata,
  input  logic [LINE_SIZE-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {G_I, G_DR, G_DW} grant_t;
  state_t state, state_n;
  grant_t grant, grant_n;
  logic [3:0] cnt;
  logic last_grant_d, req, d_pick;
  logic [WORD_SIZE-1:0] addr_q;
  logic [LINE_SIZE-1:0] wdata_q;
  always_comb begin
    req = i_readM | d_readM | d_writeM;
    d_pick = (d_readM | d_writeM) & ~(i_readM & last_grant_d);
    grant_n = d_pick ? (d_writeM ? G_DW : G_DR) : G_I;
    state_n = state == IDLE ? (req ? BUSY : IDLE) : state == BUSY ? (cnt == 4'd0 ? RESP : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= G_I;
      cnt <= 4'd0;
      last_grant_d <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        grant <= grant_n;
        last_grant_d <= d_pick;
        cnt <= 4'(MEM_LATENCY - 1);
        addr_q <= (d_pick ? d_address : i_address) & ~WORD_SIZE'(3);
        if (grant_n == G_DW) wdata_q <= d_wdata;
      end
      if (state == BUSY) begin
        cnt <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
        if (cnt == 4'd0 && grant == G_I) i_rdata <= mem_rdata;
        if (cnt == 4'd0 && grant == G_DR) d_rdata <= mem_rdata;
      end
    end
  end
  assign mem_readM   = state == BUSY && grant != G_DW;
  assign mem_writeM  = state == BUSY && grant == G_DW;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_ready     = state == RESP && grant == G_I;
  assign d_ready     = state == RESP && grant != G_I;
endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter: table, directed and randomized model-checked bench for mem_line_arbiter
module tb_mem_line_arbiter;
  localparam int L = 4;
  logic clk = 0, reset = 1;
  logic i_readM = 0, d_readM = 0, d_writeM = 0;
  logic [15:0] i_address = 0, d_address = 0;
  logic [63:0] d_wdata = 0;
  logic [63:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic i_ready, d_ready, mem_readM, mem_writeM;
  logic [15:0] mem_address;
  logic [63:0] o1_i_rdata, o1_d_rdata, o1_mem_wdata, o1_mem_rdata;
  logic o1_i_ready, o1_d_ready, o1_mem_readM, o1_mem_writeM;
  logic [15:0] o1_mem_address;
  logic [3:0] scnt = 0, scnt1 = 0;
  logic ovr_en = 0;
  logic [63:0] ovr = 0;
  int vec = 0, bad = 0;
  typedef struct {
    logic ir, dr, dw;
    logic [15:0] ia, da;
    int kind;
    logic [15:0] ea;
  } vec_t;
  vec_t tbl[8];
  always #5 clk = ~clk;
  function automatic logic [63:0] pat(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, 16'hC0DE};
  endfunction
  always @(posedge clk) scnt <= (mem_readM | mem_writeM) ? scnt + 4'd1 : 4'd0;
  always @(posedge clk) scnt1 <= (o1_mem_readM | o1_mem_writeM) ? scnt1 + 4'd1 : 4'd0;
  assign mem_rdata = (mem_readM && scnt == 4'(L - 1)) ? (ovr_en ? ovr : pat(mem_address)) : 64'hBADD_BADD_BADD_BADD;
  assign o1_mem_rdata = (o1_mem_readM && scnt1 == 4'd0) ? pat(o1_mem_address) : 64'hBADD_BADD_BADD_BADD;
  mem_line_arbiter #(.WORD_SIZE(16), .LINE_SIZE(64), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .i_readM(i_readM), .i_address(i_address), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ready(d_ready), .mem_readM(mem_readM), .mem_writeM(mem_writeM), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
  mem_line_arbiter #(.WORD_SIZE(16), .LINE_SIZE(64), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .i_readM(i_readM), .i_address(i_address), .i_rdata(o1_i_rdata), .i_ready(o1_i_ready),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata), .d_rdata(o1_d_rdata),
    .d_ready(o1_d_ready), .mem_readM(o1_mem_readM), .mem_writeM(o1_mem_writeM), .mem_address(o1_mem_address),
    .mem_wdata(o1_mem_wdata), .mem_rdata(o1_mem_rdata));
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vec++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic do_reset();
    i_readM = 0;
    d_readM = 0;
    d_writeM = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask
  task automatic drop(input int kind);
    if (kind == 1) i_readM = 0;
    if (kind == 2) d_readM = 0;
    if (kind == 3) d_writeM = 0;
  endtask
  task automatic txn(input string nm, input int kind, input logic [15:0] a, input logic [63:0] wd,
                     input logic [63:0] line, input int drop_at);
    for (int c = 1; c <= L + 2; c++) begin
      @(negedge clk);
      chk({nm, "_rd"}, mem_readM, c <= L && kind != 3);
      chk({nm, "_wr"}, mem_writeM, c <= L && kind == 3);
      if (c <= L) chk({nm, "_addr"}, mem_address, a);
      if (c <= L && kind == 3) chk({nm, "_wdata"}, mem_wdata, wd);
      chk({nm, "_irdy"}, i_ready, c == L + 1 && kind == 1);
      chk({nm, "_drdy"}, d_ready, c == L + 1 && kind != 1);
      if (c == L + 1 && kind == 1) chk({nm, "_irdata"}, i_rdata, line);
      if (c == L + 1 && kind == 2) chk({nm, "_drdata"}, d_rdata, line);
      if (c == drop_at) drop(kind);
    end
  endtask
  initial begin
    int m_kind, m_start;
    bit m_lgd, dpick, strobe, rdy;
    logic [15:0] m_addr;
    logic [63:0] m_wd, e_ir, e_dr;
    tbl[0] = '{1, 0, 0, 16'h0013, 16'h0000, 1, 16'h0010};
    tbl[1] = '{0, 1, 0, 16'h0000, 16'h1237, 2, 16'h1234};
    tbl[2] = '{0, 0, 1, 16'h0000, 16'hFFFF, 3, 16'hFFFC};
    tbl[3] = '{0, 1, 1, 16'h0000, 16'h0046, 3, 16'h0044};
    tbl[4] = '{1, 1, 0, 16'h0101, 16'h0202, 2, 16'h0200};
    tbl[5] = '{1, 0, 1, 16'h0101, 16'h0303, 3, 16'h0300};
    tbl[6] = '{1, 1, 1, 16'h0105, 16'h0406, 3, 16'h0404};
    tbl[7] = '{1, 0, 0, 16'hFFFF, 16'h0000, 1, 16'hFFFC};
    @(negedge clk);
    do_reset();
    chk("rst_irdy", i_ready, 0);
    chk("rst_drdy", d_ready, 0);
    chk("rst_rd", mem_readM, 0);
    chk("rst_wr", mem_writeM, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_irdata", i_rdata, 0);
    chk("rst_drdata", d_rdata, 0);
    for (int k = 0; k < 8; k++) begin
      do_reset();
      i_readM = tbl[k].ir;
      d_readM = tbl[k].dr;
      d_writeM = tbl[k].dw;
      i_address = tbl[k].ia;
      d_address = tbl[k].da;
      d_wdata = {32'hA5A5_0000 + 32'(k), 32'h1234_5678};
      txn($sformatf("tbl%0d", k), tbl[k].kind, tbl[k].ea, d_wdata, pat(tbl[k].ea), 0);
      do_reset();
    end
    do_reset();
    ovr_en = 1;
    ovr = 64'h1111_2222_3333_4444;
    i_readM = 1;
    i_address = 16'h0013;
    txn("t1", 1, 16'h0010, 0, ovr, L + 1);
    ovr_en = 0;
    do_reset();
    d_writeM = 1;
    d_readM = 1;
    d_address = 16'h0046;
    d_wdata = 64'hDEAD_BEEF_CAFE_0001;
    txn("t2w", 3, 16'h0044, 64'hDEAD_BEEF_CAFE_0001, 0, L + 1);
    txn("t2r", 2, 16'h0044, 0, pat(16'h0044), L + 1);
    do_reset();
    i_readM = 1;
    i_address = 16'h0100;
    d_readM = 1;
    d_address = 16'h0200;
    txn("t3d", 2, 16'h0200, 0, pat(16'h0200), L + 1);
    txn("t3i", 1, 16'h0100, 0, pat(16'h0100), L + 1);
    do_reset();
    i_readM = 1;
    i_address = 16'h0600;
    d_readM = 1;
    d_address = 16'h0700;
    for (int k = 0; k < 4; k++)
      txn($sformatf("t4_%0d", k), (k % 2) ? 1 : 2, (k % 2) ? 16'h0600 : 16'h0700, 0,
          pat((k % 2) ? 16'h0600 : 16'h0700), 0);
    do_reset();
    i_readM = 1;
    i_address = 16'h0300;
    @(negedge clk);
    chk("t5_c1_rd", mem_readM, 1);
    @(negedge clk);
    chk("t5_c2_rd", mem_readM, 1);
    reset = 1;
    i_readM = 0;
    @(negedge clk);
    reset = 0;
    chk("t5_rd", mem_readM, 0);
    chk("t5_wr", mem_writeM, 0);
    chk("t5_addr", mem_address, 0);
    chk("t5_irdata", i_rdata, 0);
    chk("t5_drdata", d_rdata, 0);
    for (int c = 0; c < L + 3; c++) begin
      @(negedge clk);
      chk("t5_noirdy", i_ready, 0);
      chk("t5_nostrobe", mem_readM | mem_writeM, 0);
    end
    i_readM = 1;
    i_address = 16'h0333;
    txn("t5_new", 1, 16'h0330, 0, pat(16'h0330), L + 1);
    do_reset();
    i_readM = 1;
    i_address = 16'h0400;
    txn("t6", 1, 16'h0400, 0, pat(16'h0400), 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_once", i_ready, 0);
    end
    do_reset();
    i_readM = 1;
    i_address = 16'h0502;
    @(negedge clk);
    chk("t6l1_rd", o1_mem_readM, 1);
    chk("t6l1_addr", o1_mem_address, 16'h0500);
    chk("t6l1_rdy0", o1_i_ready, 0);
    i_readM = 0;
    @(negedge clk);
    chk("t6l1_rdy", o1_i_ready, 1);
    chk("t6l1_rdata", o1_i_rdata, pat(16'h0500));
    chk("t6l1_rd_off", o1_mem_readM, 0);
    @(negedge clk);
    chk("t6l1_rdy_off", o1_i_ready, 0);
    chk("t6l1_idle", o1_mem_readM | o1_mem_writeM, 0);
    do_reset();
    m_kind = 0;
    m_start = 0;
    m_lgd = 0;
    m_addr = 0;
    m_wd = 0;
    e_ir = 0;
    e_dr = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      strobe = m_kind != 0 && cyc >= m_start && cyc < m_start + L;
      rdy = m_kind != 0 && cyc == m_start + L;
      chk("rnd_rd", mem_readM, strobe && m_kind != 3);
      chk("rnd_wr", mem_writeM, strobe && m_kind == 3);
      if (strobe) chk("rnd_addr", mem_address, m_addr);
      if (strobe && m_kind == 3) chk("rnd_wdata", mem_wdata, m_wd);
      chk("rnd_irdy", i_ready, rdy && m_kind == 1);
      chk("rnd_drdy", d_ready, rdy && m_kind != 1);
      if (rdy && m_kind == 1) e_ir = pat(m_addr);
      if (rdy && m_kind == 2) e_dr = pat(m_addr);
      chk("rnd_irdata", i_rdata, e_ir);
      chk("rnd_drdata", d_rdata, e_dr);
      if (rdy) drop(m_kind);
      if (!i_readM && $urandom_range(3) == 0) begin
        i_readM = 1;
        i_address = 16'($urandom);
      end
      if (!d_readM && !d_writeM && $urandom_range(3) == 0) begin
        int r;
        r = int'($urandom_range(2));
        d_readM = r != 1;
        d_writeM = r != 0;
        d_address = 16'($urandom);
        d_wdata = {$urandom, $urandom};
      end
      if ((m_kind == 0 || cyc >= m_start + L + 1) && (i_readM || d_readM || d_writeM)) begin
        dpick = (d_readM || d_writeM) && !(i_readM && m_lgd);
        m_kind = dpick ? (d_writeM ? 3 : 2) : 1;
        m_lgd = dpick;
        m_addr = (dpick ? d_address : i_address) & 16'hFFFC;
        m_wd = d_wdata;
        m_start = cyc + 1;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
